// File: rtl/alu16.sv
// ---------------------------------------------------------------------------
// alu16 : registered 16-bit integer ALU for the RISC16 datapath.
//
// Computes one of eight unsigned operations on a/b when in_valid is sampled
// high, and registers result, zero and carry with one cycle of latency.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   a            in   operand A                              [WIDTH]
//   b            in   operand B / shift amount               [WIDTH]
//   alu_control  in   operation select                       [3]
//   in_valid     in   operands valid, sampled on rising clk
//   result       out  registered operation result            [WIDTH]
//   zero         out  registered flag, result == 0
//   carry        out  registered carry-out (ADD) / borrow (SUB), else 0
//   out_valid    out  one-cycle pulse when outputs hold a new value
// ---------------------------------------------------------------------------
module alu16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_control,
   input  logic             in_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             out_valid
);

   localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_SHL = 3'b011;
   localparam logic [2:0] OP_SHR = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   // Extended adder/subtractor; the extra MSB is carry-out or borrow.
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic               w_borrow;
   logic               w_shift_oob;
   logic [SHW-1:0]     w_shamt;
   logic [WIDTH-1:0]   w_shl;
   logic [WIDTH-1:0]   w_shr;
   logic [WIDTH-1:0]   w_result;
   logic               w_carry;
   logic               w_zero;

   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_carry;
   logic               r_out_valid;

   assign w_sum    = {1'b0, a} + {1'b0, b};
   assign w_diff   = {1'b0, a} - {1'b0, b};
   // Borrow out of the extended subtraction is exactly the unsigned a < b.
   assign w_borrow = w_diff[WIDTH];

   // Shift amounts of WIDTH or more flush the operand to zero.
   assign w_shift_oob = (b >= WIDTH'(WIDTH));
   assign w_shamt     = b[SHW-1:0];
   assign w_shl       = w_shift_oob ? '0 : (a << w_shamt);
   assign w_shr       = w_shift_oob ? '0 : (a >> w_shamt);

   // Operation select.
   always_comb begin
      w_result = '0;
      w_carry  = 1'b0;
      case (alu_control)
         OP_ADD: begin
            w_result = w_sum[WIDTH-1:0];
            w_carry  = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_result = w_diff[WIDTH-1:0];
            w_carry  = w_borrow;
         end
         OP_NOT: w_result = ~a;
         OP_SHL: w_result = w_shl;
         OP_SHR: w_result = w_shr;
         OP_AND: w_result = a & b;
         OP_OR:  w_result = a | b;
         OP_CMP: w_result = {{(WIDTH-1){1'b0}}, w_borrow};
         default: begin
            w_result = '0;
            w_carry  = 1'b0;
         end
      endcase
   end

   // Zero flag derives from the next result so it never lags it.
   assign w_zero = (w_result == '0);

   // Output registers; outputs hold when no operands are presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_result <= w_result;
            r_zero   <= w_zero;
            r_carry  <= w_carry;
         end
      end
   end

   assign result    = r_result;
   assign zero      = r_zero;
   assign carry     = r_carry;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu16.sv
// ---------------------------------------------------------------------------
// tb_alu16 : self-checking bench for alu16 using a table of directed vectors
// plus hand-written sequences for reset, hold and back-to-back behaviour.
// ---------------------------------------------------------------------------
module tb_alu16;

   localparam int unsigned WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       alu_control;
   logic             in_valid;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp_res;
      logic             exp_zero;
      logic             exp_carry;
   } vec_t;

   vec_t vecs[19];

   alu16 #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .in_valid    (in_valid),
      .result      (result),
      .zero        (zero),
      .carry       (carry),
      .out_valid   (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic [WIDTH-1:0] r,
                          input logic z, input logic c, input logic v);
      chk({name, ".result"},    32'(result),    32'(r));
      chk({name, ".zero"},      32'(zero),      32'(z));
      chk({name, ".carry"},     32'(carry),     32'(c));
      chk({name, ".out_valid"}, 32'(out_valid), 32'(v));
   endtask

   // Present one operation on the falling edge and sample 1 ns after capture.
   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb);
      @(negedge clk);
      alu_control = op;
      a           = va;
      b           = vb;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      @(negedge clk);
      in_valid    = 1'b0;
      a           = va;
      b           = vb;
      alu_control = 3'b000;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             op      a         b         result    z     c
      vecs[0]  = '{3'b000, 16'd0,    16'd0,    16'd0,    1'b1, 1'b0};
      vecs[1]  = '{3'b000, 16'd10,   16'd20,   16'd30,   1'b0, 1'b0};
      vecs[2]  = '{3'b000, 16'hFFFF, 16'd1,    16'd0,    1'b1, 1'b1};
      vecs[3]  = '{3'b000, 16'h8000, 16'h8000, 16'd0,    1'b1, 1'b1};
      vecs[4]  = '{3'b001, 16'd20,   16'd10,   16'd10,   1'b0, 1'b0};
      vecs[5]  = '{3'b001, 16'd10,   16'd20,   16'd65526,1'b0, 1'b1};
      vecs[6]  = '{3'b001, 16'd5,    16'd5,    16'd0,    1'b1, 1'b0};
      vecs[7]  = '{3'b010, 16'd1,    16'd77,   16'd65534,1'b0, 1'b0};
      vecs[8]  = '{3'b010, 16'hFFFF, 16'd0,    16'd0,    1'b1, 1'b0};
      vecs[9]  = '{3'b011, 16'd1,    16'd3,    16'd8,    1'b0, 1'b0};
      vecs[10] = '{3'b100, 16'd8,    16'd3,    16'd1,    1'b0, 1'b0};
      vecs[11] = '{3'b011, 16'd1,    16'd16,   16'd0,    1'b1, 1'b0};
      vecs[12] = '{3'b011, 16'd1,    16'd15,   16'h8000, 1'b0, 1'b0};
      vecs[13] = '{3'b100, 16'h8000, 16'd15,   16'd1,    1'b0, 1'b0};
      vecs[14] = '{3'b100, 16'hFFFF, 16'd100,  16'd0,    1'b1, 1'b0};
      vecs[15] = '{3'b101, 16'd1,    16'd1025, 16'd1,    1'b0, 1'b0};
      vecs[16] = '{3'b110, 16'd1,    16'd1025, 16'd1025, 1'b0, 1'b0};
      vecs[17] = '{3'b111, 16'd1024, 16'd2048, 16'd1,    1'b0, 1'b0};
      vecs[18] = '{3'b111, 16'd5,    16'd5,    16'd0,    1'b1, 1'b0};

      rst_n       = 1'b1;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      alu_control = 3'b000;

      // Asynchronous reset before any clock edge.
      #2 rst_n = 1'b0;
      #1 chk_out("reset_async", 16'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_out("reset_hold", 16'd0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 19; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         chk_out($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_zero,
                 vecs[i].exp_carry, 1'b1);
      end

      // Carry and result hold across idle cycles while inputs wiggle.
      issue(3'b000, 16'hFFFF, 16'd1);
      chk_out("carry_set", 16'd0, 1'b1, 1'b1, 1'b1);
      idle_cycle(16'd3, 16'd4);
      chk_out("carry_hold", 16'd0, 1'b1, 1'b1, 1'b0);
      idle_cycle(16'h1234, 16'h0001);
      chk_out("carry_hold2", 16'd0, 1'b1, 1'b1, 1'b0);

      // Back-to-back CMP, then drop in_valid.
      issue(3'b111, 16'd1024, 16'd2048);
      chk_out("b2b_0", 16'd1, 1'b0, 1'b0, 1'b1);
      issue(3'b111, 16'd1024, 16'd512);
      chk_out("b2b_1", 16'd0, 1'b1, 1'b0, 1'b1);
      idle_cycle(16'd7, 16'd9);
      chk_out("b2b_drop", 16'd0, 1'b1, 1'b0, 1'b0);

      // Inputs changing between edges must not reach the outputs.
      issue(3'b000, 16'd10, 16'd20);
      chk_out("mid_base", 16'd30, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      a        = 16'hFFFF;
      b        = 16'hFFFF;
      #2 chk_out("mid_change", 16'd30, 1'b0, 1'b0, 1'b1);

      // Reset mid-operation discards the pending capture.
      alu_control = 3'b110;
      a           = 16'h00F0;
      b           = 16'h000F;
      in_valid    = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_out("reset_mid", 16'd0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 chk_out("reset_edge", 16'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1 chk_out("reset_discard", 16'd0, 1'b1, 1'b0, 1'b0);

      // First capture after reset.
      issue(3'b110, 16'h00F0, 16'h000F);
      chk_out("post_reset", 16'h00FF, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
